// File: rtl/mux_scan_nx1_if.sv
// Request/response bundle for the N:1 scanning mux.
// The master side drives requests and out_ready; the slave side (the mux) drives results.
interface mux_scan_nx1_if #(
    parameter int N = 8,
    parameter int W = 1
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] data_in;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           in_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           busy;
    logic           done;

    modport master (
        output data_in, sel, mode, in_valid, out_ready,
        input  out_data, out_sel, out_valid, busy, done
    );

    modport slave (
        input  data_in, sel, mode, in_valid, out_ready,
        output out_data, out_sel, out_valid, busy, done
    );
endinterface

// File: rtl/mux_scan_nx1.sv
// N:1 channel mux with a manual single-pick mode and a scan mode that
// snapshots all channels and emits them one per handshake, index 0..N-1.
// N must be a power of two (>= 2) so the select exactly covers the channels.
module mux_scan_nx1 #(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_scan_nx1_if.slave bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic [SW-1:0]  out_sel_q,   out_sel_d;
    logic           out_valid_q, out_valid_d;
    logic           done_q,      done_d;
    logic [N*W-1:0] snap_q,      snap_d;

    // Unpacked channel views so the select can index them directly.
    logic [W-1:0]   live_ch [N];
    logic [W-1:0]   snap_ch [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign live_ch[k] = bus.data_in[k*W +: W];
        assign snap_ch[k] = snap_q[k*W +: W];
    end

    logic          hs;
    logic [SW-1:0] nxt_sel;

    assign hs      = out_valid_q & bus.out_ready;
    assign nxt_sel = out_sel_q + SW'(1);

    // Next-state and output computation for the IDLE/HOLD/SCAN machine.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        snap_d      = snap_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    out_valid_d = 1'b1;
                    if (!bus.mode) begin
                        out_data_d = live_ch[bus.sel];
                        out_sel_d  = bus.sel;
                        state_d    = HOLD;
                    end else begin
                        snap_d     = bus.data_in;
                        out_data_d = live_ch[0];
                        out_sel_d  = '0;
                        state_d    = SCAN;
                    end
                end
            end
            HOLD: begin
                // A fresh manual pick arriving with the handshake keeps the
                // output stream full with no bubble.
                if (hs) begin
                    if (bus.in_valid && !bus.mode) begin
                        out_data_d = live_ch[bus.sel];
                        out_sel_d  = bus.sel;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            SCAN: begin
                // Requests are ignored here; the last beat ends the scan.
                if (hs) begin
                    if (out_sel_q != SW'(N-1)) begin
                        out_sel_d  = nxt_sel;
                        out_data_d = snap_ch[nxt_sel];
                    end else begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any pick or scan in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            snap_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            snap_q      <= snap_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: a vector table for the N=8/W=1 instance
// plus hand sequences for reset aborts and the N=4/W=4 scan.
module tb_mux_scan_nx1;
    logic clk;
    logic rst_n;

    mux_scan_nx1_if #(.N(8), .W(1)) bus8 ();
    mux_scan_nx1_if #(.N(4), .W(4)) bus4 ();

    mux_scan_nx1 #(.N(8), .W(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    mux_scan_nx1 #(.N(4), .W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       iv;
        logic       md;
        logic [2:0] sel;
        logic [7:0] din;
        logic       rdy;
        logic       ev;
        logic       ed;
        logic [2:0] es;
        logic       edone;
        logic       ebusy;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic iv, logic md, logic [2:0] sel, logic [7:0] din, logic rdy,
                                logic ev, logic ed, logic [2:0] es, logic edone, logic ebusy);
        vec_t v;
        v.iv = iv; v.md = md; v.sel = sel; v.din = din; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.es = es; v.edone = edone; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic v, input logic d, input logic [2:0] s,
                        input logic dn, input logic b);
        chk({tag, " out_valid"}, 32'(bus8.out_valid), 32'(v));
        if (v) begin
            chk({tag, " out_data"}, 32'(bus8.out_data), 32'(d));
            chk({tag, " out_sel"},  32'(bus8.out_sel),  32'(s));
        end
        chk({tag, " done"}, 32'(bus8.done), 32'(dn));
        chk({tag, " busy"}, 32'(bus8.busy), 32'(b));
    endtask

    // Safety net: never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;

        // rows: iv md sel din rdy | ev ed es done busy
        // manual pick of channel 5, then release
        tbl[0]  = mk(1, 0, 5, 8'h20, 1,  1, 1, 5, 0, 1);
        tbl[1]  = mk(0, 0, 0, 8'h20, 1,  0, 0, 0, 0, 0);
        // backpressure for 3 cycles with data_in/sel/mode disturbed
        tbl[2]  = mk(1, 0, 5, 8'h20, 0,  1, 1, 5, 0, 1);
        tbl[3]  = mk(0, 0, 5, 8'h00, 0,  1, 1, 5, 0, 1);
        tbl[4]  = mk(1, 1, 0, 8'h00, 0,  1, 1, 5, 0, 1);
        tbl[5]  = mk(0, 0, 0, 8'h00, 0,  1, 1, 5, 0, 1);
        tbl[6]  = mk(0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0);
        // back-to-back manual picks 2,3,4 on 8'b0001_0100
        tbl[7]  = mk(1, 0, 2, 8'h14, 1,  1, 1, 2, 0, 1);
        tbl[8]  = mk(1, 0, 3, 8'h14, 1,  1, 0, 3, 0, 1);
        tbl[9]  = mk(1, 0, 4, 8'h14, 1,  1, 1, 4, 0, 1);
        tbl[10] = mk(0, 0, 0, 8'h14, 1,  0, 0, 0, 0, 0);
        // scan of 8'hA5 with data_in churn, an ignored request and one stall
        tbl[11] = mk(1, 1, 0, 8'hA5, 1,  1, 1, 0, 0, 1);
        tbl[12] = mk(1, 0, 6, 8'h00, 1,  1, 0, 1, 0, 1);
        tbl[13] = mk(0, 0, 0, 8'hFF, 1,  1, 1, 2, 0, 1);
        tbl[14] = mk(0, 0, 0, 8'h00, 1,  1, 0, 3, 0, 1);
        tbl[15] = mk(0, 0, 0, 8'h00, 0,  1, 0, 3, 0, 1);
        tbl[16] = mk(0, 0, 0, 8'h00, 1,  1, 0, 4, 0, 1);
        tbl[17] = mk(0, 0, 0, 8'hFF, 1,  1, 1, 5, 0, 1);
        tbl[18] = mk(0, 0, 0, 8'h00, 1,  1, 0, 6, 0, 1);
        tbl[19] = mk(0, 0, 0, 8'h00, 1,  1, 1, 7, 0, 1);
        // last beat: request during SCAN ignored, done pulses
        tbl[20] = mk(1, 0, 1, 8'h02, 1,  0, 0, 0, 1, 0);
        // request accepted from IDLE on the cycle after done
        tbl[21] = mk(1, 0, 1, 8'h02, 1,  1, 1, 1, 0, 1);
        tbl[22] = mk(0, 0, 0, 8'h02, 1,  0, 0, 0, 0, 0);

        bus8.data_in = '0; bus8.sel = '0; bus8.mode = 0; bus8.in_valid = 0; bus8.out_ready = 0;
        bus4.data_in = '0; bus4.sel = '0; bus4.mode = 0; bus4.in_valid = 0; bus4.out_ready = 0;
        rst_n = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk8("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("reset out_data", 32'(bus8.out_data), 32'd0);
        chk("reset out_sel",  32'(bus8.out_sel),  32'd0);
        chk("reset4 out_valid", 32'(bus4.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table on the 8x1 instance
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            bus8.in_valid = tbl[i].iv;
            bus8.mode     = tbl[i].md;
            bus8.sel      = tbl[i].sel;
            bus8.data_in  = tbl[i].din;
            bus8.out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk8($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].edone, tbl[i].ebusy);
        end

        // reset mid-hold, then a request applied at release is taken on the first edge
        @(negedge clk);
        bus8.in_valid = 1; bus8.mode = 0; bus8.sel = 5; bus8.data_in = 8'h20; bus8.out_ready = 0;
        @(posedge clk); #1;
        chk8("hold pre-reset", 1'b1, 1'b1, 3'd5, 1'b0, 1'b1);
        @(negedge clk);
        bus8.in_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        chk8("hold async reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("hold async reset out_data", 32'(bus8.out_data), 32'd0);
        chk("hold async reset out_sel",  32'(bus8.out_sel),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus8.in_valid = 1; bus8.mode = 0; bus8.sel = 3; bus8.data_in = 8'h08; bus8.out_ready = 1;
        @(posedge clk); #1;
        chk8("first edge after reset", 1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
        @(negedge clk);
        bus8.in_valid = 0;
        @(posedge clk); #1;
        chk8("first pick release", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // reset mid-scan at out_sel=3
        @(negedge clk);
        bus8.in_valid = 1; bus8.mode = 1; bus8.data_in = 8'hA5; bus8.out_ready = 1;
        @(posedge clk); #1;
        chk8("scan2 beat0", 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus8.in_valid = 0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (bus8.out_sel == 3'd3) found = 1'b1;
        end
        chk("scan2 reached sel3", 32'(found), 32'd1);
        chk8("scan2 beat3", 1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk8("scan async reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("scan async reset out_data", 32'(bus8.out_data), 32'd0);
        chk("scan async reset out_sel",  32'(bus8.out_sel),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk8($sformatf("post-reset idle%0d", c), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        bus8.in_valid = 1; bus8.mode = 1; bus8.data_in = 8'h5A;
        @(posedge clk); #1;
        chk8("rescan beat0", 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus8.in_valid = 0;
        @(posedge clk); #1;
        chk8("rescan beat1", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        chk8("rescan end", 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

        // N=4, W=4 scan of 16'hDCBA
        @(negedge clk);
        bus4.in_valid = 1; bus4.mode = 1; bus4.data_in = 16'hDCBA; bus4.out_ready = 1;
        @(posedge clk); #1;
        chk("n4 beat0 data", 32'(bus4.out_data), 32'hA);
        chk("n4 beat0 sel",  32'(bus4.out_sel),  32'd0);
        @(negedge clk);
        bus4.in_valid = 0; bus4.data_in = 16'h0000;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("n4 beat%0d data", k), 32'(bus4.out_data), 32'hA + 32'(k));
            chk($sformatf("n4 beat%0d sel", k),  32'(bus4.out_sel),  32'(k));
            chk($sformatf("n4 beat%0d valid", k), 32'(bus4.out_valid), 32'd1);
        end
        @(posedge clk); #1;
        chk("n4 done", 32'(bus4.done), 32'd1);
        chk("n4 end valid", 32'(bus4.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("n4 done pulse width", 32'(bus4.done), 32'd0);
        chk("n4 busy idle", 32'(bus4.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
